// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin, burst-bounded sharing of one single-port data memory between CPU and loader ports
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_adr,
  input  logic [DATA_WIDTH-1:0] m0_wd,
  output logic [DATA_WIDTH-1:0] m0_rd,
  output logic                  m0_gnt,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_adr,
  input  logic [DATA_WIDTH-1:0] m1_wd,
  output logic [DATA_WIDTH-1:0] m1_rd,
  output logic                  m1_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
  localparam logic [7:0] BEAT_LIM = 8'(MAX_BURST - 1);
  state_t     r_state, w_state_nx;
  logic [7:0] r_beat, w_beat_nx;
  logic       r_last, w_last_nx;
  logic       w_own1, w_own_req, w_oth_req;
  assign w_own1    = (r_state == OWN1);
  assign w_own_req = w_own1 ? m1_req : m0_req;
  assign w_oth_req = w_own1 ? m0_req : m1_req;
  // Owner yields once its tenure reaches the limit, even if it grew uncontended first
  always_comb begin
    w_state_nx = r_state;
    w_beat_nx  = r_beat;
    w_last_nx  = r_last;
    if (r_state == IDLE) begin
      w_beat_nx  = 8'd0;
      w_state_nx = (m0_req && m1_req) ? (r_last ? OWN0 : OWN1) :
                   m0_req ? OWN0 : m1_req ? OWN1 : IDLE;
    end else if (!w_own_req || (r_beat >= BEAT_LIM && w_oth_req)) begin
      w_last_nx  = w_own1;
      w_beat_nx  = 8'd0;
      w_state_nx = !w_oth_req ? IDLE : w_own1 ? OWN0 : OWN1;
    end else begin
      w_beat_nx = r_beat + {7'd0, r_beat != 8'hFF};
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_beat  <= 8'd0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_beat  <= w_beat_nx;
      r_last  <= w_last_nx;
    end
  end
  assign m0_gnt  = (r_state == OWN0);
  assign m1_gnt  = (r_state == OWN1);
  assign busy    = (r_state != IDLE);
  assign mem_adr = m0_gnt ? m0_adr : m1_gnt ? m1_adr : '0;
  assign mem_wd  = m0_gnt ? m0_wd : m1_gnt ? m1_wd : '0;
  assign mem_we  = reset & ((m0_gnt & m0_req & m0_we) | (m1_gnt & m1_req & m1_we));
  assign m0_rd   = mem_rd;
  assign m1_rd   = mem_rd;
endmodule
